// File: rtl/axi_lite_ctrl_master.sv
// axi_lite_ctrl_master
// AXI4-Lite initiator for a kernel s_axi_control port. A command stream
// issues single writes, single reads, or masked poll loops (read until
// (rdata & mask) == (wdata & mask), an error response, or the read limit).
// One transaction is outstanding at a time; every output is a register.
//
// Ports
//   clock, reset          sole clock, synchronous active-high reset
//   cmd_*                 command stream (op: 00 write, 01 read, 10 poll, 11 illegal)
//   rsp_*                 response stream (rdata, resp, timeout, read count)
//   m_axi_aw*/w*/b*       AXI4-Lite write channels
//   m_axi_ar*/r*          AXI4-Lite read channels
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | cmd_ready high, waiting for a command
// WR    | awvalid/wvalid offered, each drops after its own handshake
// WB    | bready high, waiting for the write response
// RA    | arvalid offered (raised one cycle after entry on poll retries)
// RD    | rready high, waiting for read data; poll decision made here
// RSP   | rsp_valid high, outputs frozen until rsp_ready
module axi_lite_ctrl_master #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    input  logic [DATA_WIDTH-1:0] cmd_mask,
    input  logic [CNT_WIDTH-1:0]  cmd_limit,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic [CNT_WIDTH-1:0]  rsp_count,

    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,

    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,

    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    input  logic [1:0]            m_axi_bresp,

    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,

    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp
);

    typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;

    state_t                  state;
    logic                    poll_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   mask_q;
    logic [CNT_WIDTH-1:0]    limit_q;
    logic                    aw_done;
    logic                    w_done;

    logic                    aw_fire;
    logic                    w_fire;
    logic                    poll_hit;
    logic                    limit_hit;

    // Address and write data come straight from the command registers, which
    // only change in IDLE, so the payload is stable while any valid is high.
    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    assign aw_fire   = m_axi_awvalid & m_axi_awready;
    assign w_fire    = m_axi_wvalid & m_axi_wready;
    assign poll_hit  = (m_axi_rdata & mask_q) == (wdata_q & mask_q);
    // rsp_count already includes the read being completed in RD.
    assign limit_hit = (limit_q != '0) && (rsp_count == limit_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            poll_q        <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            mask_q        <= '0;
            limit_q       <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            rsp_timeout   <= 1'b0;
            rsp_count     <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wstrb   <= '0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready   <= 1'b0;
                        poll_q      <= (cmd_op == 2'b10);
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        mask_q      <= cmd_mask;
                        limit_q     <= cmd_limit;
                        m_axi_wstrb <= cmd_wstrb;
                        rsp_count   <= '0;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= '0;
                        rsp_resp    <= 2'b00;
                        case (cmd_op)
                            2'b00: begin
                                state         <= WR;
                                m_axi_awvalid <= 1'b1;
                                m_axi_wvalid  <= 1'b1;
                                aw_done       <= 1'b0;
                                w_done        <= 1'b0;
                            end
                            2'b01, 2'b10: begin
                                state         <= RA;
                                m_axi_arvalid <= 1'b1;
                            end
                            default: begin
                                state     <= RSP;
                                rsp_valid <= 1'b1;
                                rsp_resp  <= 2'b10;
                            end
                        endcase
                    end
                end

                WR: begin
                    if (aw_fire) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_fire) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done | aw_fire) && (w_done | w_fire)) begin
                        state        <= WB;
                        m_axi_bready <= 1'b1;
                    end
                end

                WB: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        rsp_resp     <= m_axi_bresp;
                        rsp_rdata    <= '0;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end

                RA: begin
                    // Poll retries arrive here with arvalid low, leaving one
                    // idle bus cycle between consecutive reads.
                    if (!m_axi_arvalid) begin
                        m_axi_arvalid <= 1'b1;
                    end else if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        if (rsp_count != {CNT_WIDTH{1'b1}}) begin
                            rsp_count <= rsp_count + 1'b1;
                        end
                        state <= RD;
                    end
                end

                RD: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rsp_rdata    <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                        if (!poll_q || (m_axi_rresp != 2'b00) || poll_hit) begin
                            rsp_valid <= 1'b1;
                            state     <= RSP;
                        end else if (limit_hit) begin
                            rsp_valid   <= 1'b1;
                            rsp_timeout <= 1'b1;
                            state       <= RSP;
                        end else begin
                            state <= RA;
                        end
                    end
                end

                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_ctrl_master.sv
// tb_axi_lite_ctrl_master
// Directed bench: a small AXI4-Lite slave with programmable AW/W ready
// delays and a read-data table, a bus monitor counting beats and flagging
// protocol breaks, and hand-computed expectations per command.
module tb_axi_lite_ctrl_master;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata, cmd_mask;
    logic [SW-1:0] cmd_wstrb;
    logic [CW-1:0] cmd_limit;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;
    logic [CW-1:0] rsp_count;
    logic          m_axi_awvalid, m_axi_awready;
    logic [AW-1:0] m_axi_awaddr;
    logic [2:0]    m_axi_awprot;
    logic          m_axi_wvalid, m_axi_wready;
    logic [DW-1:0] m_axi_wdata;
    logic [SW-1:0] m_axi_wstrb;
    logic          m_axi_bvalid, m_axi_bready;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_arvalid, m_axi_arready;
    logic [AW-1:0] m_axi_araddr;
    logic [2:0]    m_axi_arprot;
    logic          m_axi_rvalid, m_axi_rready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;

    always #5 clock = ~clock;

    axi_lite_ctrl_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .cmd_mask(cmd_mask), .cmd_limit(cmd_limit),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .rsp_count(rsp_count),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_bresp(m_axi_bresp),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- slave configuration and bus monitor ----------------
    int            aw_delay = 0, w_delay = 0;
    logic [DW-1:0] rd_data [8];
    logic [1:0]    rd_resp [8];
    int            aw_beats = 0, w_beats = 0, ar_beats = 0, valid_cycles = 0, viol = 0;
    int            r_idx = 0;
    bit            aw_got = 0, w_got = 0, b_pending = 0, r_pending = 0;
    logic [AW-1:0] last_awaddr = '0, last_araddr = '0;
    logic [DW-1:0] last_wdata = '0;
    logic [SW-1:0] last_wstrb = '0;
    bit            p_awv = 0, p_wv = 0, p_arv = 0;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata;

    always @(posedge clock) begin
        if (reset) begin
            aw_got = 0; w_got = 0; b_pending = 0; r_pending = 0;
            p_awv = 0; p_wv = 0; p_arv = 0;
        end else begin
            if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) valid_cycles++;
            if ((m_axi_awvalid || m_axi_wvalid) && m_axi_arvalid) viol++;
            if (p_awv && (!m_axi_awvalid || m_axi_awaddr != p_awaddr)) viol++;
            if (p_wv && (!m_axi_wvalid || m_axi_wdata != p_wdata)) viol++;
            if (p_arv && (!m_axi_arvalid || m_axi_araddr != p_araddr)) viol++;
            p_awv = m_axi_awvalid && !m_axi_awready; p_awaddr = m_axi_awaddr;
            p_wv  = m_axi_wvalid && !m_axi_wready;   p_wdata  = m_axi_wdata;
            p_arv = m_axi_arvalid && !m_axi_arready; p_araddr = m_axi_araddr;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_beats++; aw_got = 1; last_awaddr = m_axi_awaddr;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_beats++; w_got = 1; last_wdata = m_axi_wdata; last_wstrb = m_axi_wstrb;
            end
            if (m_axi_bvalid && m_axi_bready) b_pending = 0;
            if (aw_got && w_got) begin
                b_pending = 1; aw_got = 0; w_got = 0;
            end
            if (m_axi_rvalid && m_axi_rready) begin
                r_pending = 0; r_idx++;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                ar_beats++; r_pending = 1; last_araddr = m_axi_araddr;
            end
        end
    end

    initial begin
        int aw_wait = 0, w_wait = 0, k;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 2'b00;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
        forever begin
            @(negedge clock);
            if (reset) begin
                aw_wait = 0; w_wait = 0;
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
                m_axi_arready = 0; m_axi_rvalid = 0;
            end else begin
                if (m_axi_awvalid) begin aw_wait++; m_axi_awready = (aw_wait > aw_delay); end
                else begin aw_wait = 0; m_axi_awready = 0; end
                if (m_axi_wvalid) begin w_wait++; m_axi_wready = (w_wait > w_delay); end
                else begin w_wait = 0; m_axi_wready = 0; end
                m_axi_bvalid  = b_pending;
                m_axi_bresp   = 2'b00;
                m_axi_arready = m_axi_arvalid;
                k = (r_idx > 7) ? 7 : r_idx;
                m_axi_rvalid  = r_pending;
                m_axi_rdata   = rd_data[k];
                m_axi_rresp   = rd_resp[k];
            end
        end
    end

    // ---------------- command / response helpers ----------------
    task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input logic [SW-1:0] st,
                            input logic [DW-1:0] mk, input logic [CW-1:0] lim);
        int n = 0;
        @(negedge clock);
        cmd_valid = 1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
        cmd_wstrb = st; cmd_mask = mk; cmd_limit = lim;
        while (!cmd_ready && n < 50) begin @(negedge clock); n++; end
        if (!cmd_ready) begin
            check_val("cmd_accept_timeout", 0, 1);
            cmd_valid = 0;
            return;
        end
        @(negedge clock);
        cmd_valid = 0;
    endtask

    logic          hold_stable;
    logic          hold_crdy_low;

    // lat is 1 when rsp_valid is already up one cycle after acceptance.
    task automatic get_rsp(input int hold, output int lat, output logic [DW-1:0] rd,
                           output logic [1:0] rs, output logic to, output logic [CW-1:0] cnt);
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(negedge clock); lat++; end
        rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout; cnt = rsp_count;
        if (!rsp_valid) begin
            check_val("rsp_wait_timeout", 0, 1);
            return;
        end
        hold_stable = 1; hold_crdy_low = !cmd_ready;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            if (!rsp_valid || rsp_rdata != rd || rsp_resp != rs ||
                rsp_timeout != to || rsp_count != cnt) hold_stable = 0;
            if (cmd_ready) hold_crdy_low = 0;
        end
        rsp_ready = 1;
        @(negedge clock);
        rsp_ready = 0;
    endtask

    int            lat, a0, w0, r0, v0;
    logic [DW-1:0] rd;
    logic [1:0]    rs;
    logic          to;
    logic [CW-1:0] cnt;

    initial begin
        reset = 1; cmd_valid = 0; rsp_ready = 0;
        cmd_op = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; cmd_mask = 0; cmd_limit = 0;
        for (int i = 0; i < 8; i++) begin rd_data[i] = '0; rd_resp[i] = 2'b00; end
        repeat (3) @(negedge clock);
        reset = 0;

        // reset state
        check_val("rst_cmd_ready", cmd_ready, 1);
        check_val("rst_valids", {rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                                 m_axi_bready, m_axi_rready}, 0);
        check_val("rst_rsp_fields", {rsp_rdata, rsp_resp, rsp_timeout, rsp_count}, 0);
        check_val("rst_prot", {m_axi_awprot, m_axi_arprot}, 0);

        // write, AW ready 3 cycles after W
        aw_delay = 3; w_delay = 0; a0 = aw_beats; w0 = w_beats;
        send_cmd(2'b00, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0);
        get_rsp(0, lat, rd, rs, to, cnt);
        check_val("wr_aw_beats", aw_beats - a0, 1);
        check_val("wr_w_beats", w_beats - w0, 1);
        check_val("wr_awaddr", last_awaddr, 12'h010);
        check_val("wr_wdata", last_wdata, 32'hDEADBEEF);
        check_val("wr_wstrb", last_wstrb, 4'hF);
        check_val("wr_resp", rs, 0);
        check_val("wr_count", cnt, 0);
        check_val("wr_rdata", rd, 0);
        check_val("wr_latency", lat, 6);

        // zero-wait write
        aw_delay = 0;
        send_cmd(2'b00, 12'h014, 32'h00000001, 4'h3, 0, 0);
        get_rsp(0, lat, rd, rs, to, cnt);
        check_val("wr0_latency", lat, 3);
        check_val("wr0_wstrb", last_wstrb, 4'h3);

        // single read
        rd_data[0] = 32'h00000004; r_idx = 0; r0 = ar_beats;
        send_cmd(2'b01, 12'h000, 0, 0, 0, 0);
        get_rsp(0, lat, rd, rs, to, cnt);
        check_val("rd_rdata", rd, 32'h4);
        check_val("rd_resp", rs, 0);
        check_val("rd_count", cnt, 1);
        check_val("rd_ar_beats", ar_beats - r0, 1);
        check_val("rd_latency", lat, 3);

        // poll, unlimited, matches on third read
        rd_data[0] = 0; rd_data[1] = 0; rd_data[2] = 32'h2; r_idx = 0; r0 = ar_beats;
        send_cmd(2'b10, 12'h000, 32'h2, 0, 32'h2, 0);
        get_rsp(0, lat, rd, rs, to, cnt);
        check_val("poll_count", cnt, 3);
        check_val("poll_ar_beats", ar_beats - r0, 3);
        check_val("poll_timeout", to, 0);
        check_val("poll_rdata", rd, 32'h2);
        check_val("poll_latency", lat, 9);

        // poll, limit 4, never matches
        rd_data[0] = 32'h1; rd_data[1] = 32'h5; rd_data[2] = 32'h9; rd_data[3] = 32'hD;
        for (int i = 4; i < 8; i++) rd_data[i] = 32'h1;
        r_idx = 0; r0 = ar_beats;
        send_cmd(2'b10, 12'h008, 32'h2, 0, 32'h2, 4);
        get_rsp(0, lat, rd, rs, to, cnt);
        check_val("plim_count", cnt, 4);
        check_val("plim_ar_beats", ar_beats - r0, 4);
        check_val("plim_timeout", to, 1);
        check_val("plim_rdata", rd, 32'hD);
        check_val("plim_araddr", last_araddr, 12'h008);

        // poll hit by SLVERR on second read
        for (int i = 0; i < 8; i++) begin rd_data[i] = 0; rd_resp[i] = 2'b00; end
        rd_resp[1] = 2'b10; r_idx = 0; r0 = ar_beats;
        send_cmd(2'b10, 12'h000, 32'h2, 0, 32'h2, 0);
        get_rsp(0, lat, rd, rs, to, cnt);
        check_val("perr_resp", rs, 2'b10);
        check_val("perr_count", cnt, 2);
        check_val("perr_ar_beats", ar_beats - r0, 2);
        check_val("perr_timeout", to, 0);
        rd_resp[1] = 2'b00;

        // illegal op
        v0 = valid_cycles;
        send_cmd(2'b11, 12'h020, 32'hFFFF, 4'hF, 0, 0);
        get_rsp(0, lat, rd, rs, to, cnt);
        check_val("ill_resp", rs, 2'b10);
        check_val("ill_bus_quiet", valid_cycles - v0, 0);
        check_val("ill_latency", lat, 1);
        check_val("ill_count", cnt, 0);

        // rsp_ready held low for 5 cycles
        rd_data[0] = 32'h12345678; r_idx = 0;
        send_cmd(2'b01, 12'h004, 0, 0, 0, 0);
        get_rsp(5, lat, rd, rs, to, cnt);
        check_val("hold_rdata", rd, 32'h12345678);
        check_val("hold_stable", hold_stable, 1);
        check_val("hold_cmd_ready_low", hold_crdy_low, 1);
        check_val("hold_cmd_ready_back", cmd_ready, 1);

        // reset while in WR
        aw_delay = 50; w_delay = 50;
        send_cmd(2'b00, 12'h030, 32'hA5A5A5A5, 4'hF, 0, 0);
        check_val("mid_awvalid_up", m_axi_awvalid, 1);
        reset = 1;
        @(negedge clock);
        check_val("mid_rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                                     m_axi_bready, m_axi_rready, rsp_valid}, 0);
        check_val("mid_rst_cmd_ready", cmd_ready, 1);
        reset = 0;
        aw_delay = 0; w_delay = 0;

        // recovery read after mid-transaction reset
        rd_data[0] = 32'hCAFE0001; r_idx = 0;
        send_cmd(2'b01, 12'h000, 0, 0, 0, 0);
        get_rsp(0, lat, rd, rs, to, cnt);
        check_val("recover_rdata", rd, 32'hCAFE0001);
        check_val("recover_count", cnt, 1);

        check_val("bus_protocol_breaks", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/axi_lite_ctrl_master.md
# axi_lite_ctrl_master

AXI4-Lite initiator that drives the `s_axi_control` slave port of an RTL kernel such as `krnl_vadd_rtl`. It replaces direct MMIO pokes in simulation and bring-up tops. A simple command/response stream issues single register writes, single reads, and masked poll loops, for example waiting on `ap_done`. The block sits beside the kernel in the same clock domain and shares the kernel's reset.

## Interface
Parameters:
- `ADDR_WIDTH`, default 12: control address width.
- `DATA_WIDTH`, default 32: register width; only 32 is supported. `STRB_WIDTH` = `DATA_WIDTH`/8.
- `CNT_WIDTH`, default 16: width of the poll counter and poll limit.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  reset, synchronous and active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_op`  in  2  command opcode: 00 write, 01 read, 10 poll, 11 illegal.
- `cmd_addr`  in  `ADDR_WIDTH`  register byte address.
- `cmd_wdata`  in  `DATA_WIDTH`  write data (write) or compare value (poll).
- `cmd_wstrb`  in  `STRB_WIDTH`  write strobes.
- `cmd_mask`  in  `DATA_WIDTH`  poll mask.
- `cmd_limit`  in  `CNT_WIDTH`  maximum poll reads; 0 means unlimited.
- `rsp_valid`  out  1  response offered.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  `DATA_WIDTH`  last read data; 0 for writes.
- `rsp_resp`  out  2  AXI response code.
- `rsp_timeout`  out  1  poll limit exhausted without a match.
- `rsp_count`  out  `CNT_WIDTH`  number of reads issued for this command.
- `m_axi_awvalid`/`awready`/`awaddr`[`ADDR_WIDTH`]/`awprot`[3]  AW channel; `awprot` is tied to 000.
- `m_axi_wvalid`/`wready`/`wdata`/`wstrb`  W channel.
- `m_axi_bvalid`/`bready`/`bresp`[2]  B channel.
- `m_axi_arvalid`/`arready`/`araddr`/`arprot`[3]  AR channel; `arprot` is tied to 000.
- `m_axi_rvalid`/`rready`/`rdata`/`rresp`[2]  R channel.

## Operation
- FSM states: IDLE, WR, WB, RA, RD, RSP. On reset the FSM enters IDLE.
- Reset values: all valid and ready outputs are 0, except `cmd_ready`, which is 1 in IDLE. All data, address and response registers are 0.
- IDLE:
  - `cmd_ready`=1. On handshake, the command fields are registered and the counter is cleared.
  - op 00 goes to WR. Ops 01 and 10 go to RA.
  - op 11 goes to RSP with `rsp_resp`=10 (SLVERR) and no bus traffic.
- WR:
  - `awvalid` and `wvalid` assert together.
  - Each valid drops independently after its own handshake, tracked by `aw_done` and `w_done`.
  - When both handshakes are done, go to WB. Both may complete in the same cycle.
- WB: `bready`=1. On `bvalid`, capture `bresp`, set `rsp_rdata`=0, go to RSP.
- RA: `arvalid`=1 until `arready`. On handshake, `rsp_count` increments (saturating) and the FSM goes to RD.
- RD: `rready`=1. On `rvalid`, capture `rdata` and `rresp`. Then:
  - read op: go to RSP.
  - poll, `rresp`≠00: go to RSP.
  - poll, (`rdata` & `mask`) == (`wdata` & `mask`): go to RSP.
  - poll, `limit`≠0 and `rsp_count`==`limit`: go to RSP with `rsp_timeout`=1.
  - poll, otherwise: go back to RA.
- RSP: `rsp_valid`=1 and all outputs are held stable until `rsp_ready`. Then go to IDLE. `cmd_ready` stays 0 throughout RSP.
- Only one transaction is outstanding at a time. AW, W and AR are never active at once.
- Once asserted, a valid is held with a stable payload until its handshake completes.
- Reset mid-transaction: all valids drop at the next edge and the FSM returns to IDLE. The slave shares the same reset.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Write, zero-wait slave:
  - cycle 0: command accepted.
  - cycle 1: `awvalid`/`wvalid` high.
  - cycle 2: `bready` high.
  - `rsp_valid` asserts the cycle after `bvalid`&`bready`.
- Read: `arvalid` is high in the cycle after acceptance. `rsp_valid` asserts the cycle after `rvalid`&`rready`.
- Poll: back-to-back reads are separated by at least one idle bus cycle (RD→RA→`arvalid`).
- Illegal op: `rsp_valid` asserts the cycle after acceptance.
- `rsp_count` saturates at 2^`CNT_WIDTH`−1. With `limit`=0 the poll loop runs forever.

## Test plan
- Write to 0x010, data 0xDEADBEEF, strb 0xF; AW ready 3 cycles after W → exactly one AW and one W beat, `wdata` 0xDEADBEEF, response 00, `rsp_count`=0.
- Read from 0x000; slave returns 0x00000004 → `rsp_rdata`=0x4, `rsp_resp`=00, `rsp_count`=1.
- Poll 0x000, mask 0x2, value 0x2, limit 0; slave returns 0, 0, 0x2 → 3 AR beats, `rsp_count`=3, `rsp_timeout`=0.
- Poll with limit 4; the data never matches → 4 reads, `rsp_timeout`=1, `rsp_rdata`=last read value.
- Read where the slave returns `rresp`=10 during a poll → the poll stops immediately with `rsp_resp`=10. Separately, op 11 → SLVERR with no AXI valids ever asserted.
- `rsp_ready` held low 5 cycles → response fields stay stable and `cmd_ready` stays 0. Separately, assert `reset` in WR → all valids are 0 and `cmd_ready`=1 on the following cycle.
